multi_state_osc: RTL

- Parametrised successor to the two-state oscillating FSM.
- Cycles through NUM_STATES states, in either direction, gated by input A.
- Two advance modes:
  - level: A held high for DWELL cycles advances one state.
  - edge: each rising edge of A advances one state.
- Drives the registered state index, an odd-state flag y (the old case1/case2 toggle when NUM_STATES=2), and a one-cycle wrap pulse; used as a sequencer/oscillator front end in FSM designs.

---
 rtl/multi_state_osc.sv | 106 ++++++++++
 1 files changed

// File: rtl/multi_state_osc.sv
// multi_state_osc: NUM_STATES-step up/down sequencer advanced by A,
// in either level (dwell) or edge mode.
// Optional: define OSC_STALL_CNT_EN to add the stall_cnt output.
module multi_state_osc #(
  parameter int unsigned NUM_STATES = 4,
  parameter int unsigned DWELL      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       mode,
  input  logic       dir,
  output logic [3:0] state_o,
  output logic       y,
  output logic       wrap
`ifdef OSC_STALL_CNT_EN
  ,
  output logic [7:0] stall_cnt
`endif
);

  localparam logic [3:0] LAST       = 4'(NUM_STATES - 1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [7:0] dwell_cnt;
  logic [7:0] dwell_nxt;
  logic       A_q;
  logic       mode_q;
  logic       mode_chg;
  logic       adv;
  logic       wrap_nxt;
  logic [3:0] state_nxt;

  assign mode_chg = (mode != mode_q);

  always_comb begin
    adv       = 1'b0;
    dwell_nxt = dwell_cnt;
    if (mode_chg) begin
      dwell_nxt = '0;
    end else if (!mode) begin
      if (A) begin
        if (dwell_cnt >= DWELL_LAST) begin
          adv       = 1'b1;
          dwell_nxt = '0;
        end else begin
          dwell_nxt = dwell_cnt + 8'd1;
        end
      end
    end else begin
      dwell_nxt = '0;
      adv       = A & ~A_q;
    end
  end

  always_comb begin
    state_nxt = state_o;
    wrap_nxt  = 1'b0;
    if (adv) begin
      if (dir) begin
        if (state_o == '0) begin
          state_nxt = LAST;
          wrap_nxt  = 1'b1;
        end else begin
          state_nxt = state_o - 4'd1;
        end
      end else begin
        if (state_o == LAST) begin
          state_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          state_nxt = state_o + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_o   <= '0;
      y         <= 1'b0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
      A_q       <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_o   <= state_nxt;
      y         <= state_nxt[0];
      wrap      <= wrap_nxt;
      dwell_cnt <= dwell_nxt;
      A_q       <= A;
      mode_q    <= mode;
    end
  end

`ifdef OSC_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || adv || mode_chg) begin
      stall_cnt <= '0;
    end else if (!mode && !A && (dwell_cnt != '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`endif

endmodule
